// File: rtl/acc_word_sequencer_if.sv
// Producer-side entry handshake for the accumulator word sequencer.
// An entry transfers on a pclk edge where in_valid and in_ready are both high.
interface acc_word_sequencer_if;
  logic       in_valid;
  logic [4:0] in_word;
  logic [7:0] in_dwell;
  logic       in_ready;

  modport master (output in_valid, output in_word, output in_dwell, input  in_ready);
  modport slave  (input  in_valid, input  in_word, input  in_dwell, output in_ready);
endinterface

// File: rtl/acc_word_sequencer.sv
// Queues {word, dwell} entries and plays each word to a downstream accumulator
// for 'dwell' pclk cycles (0 means 256), back-to-back while run stays high.
module acc_word_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     pclk,
  input  logic                     reset,
  input  logic                     run,
  acc_word_sequencer_if.slave      in_if,
  output logic [4:0]               acc_in,
  output logic                     clock_enable,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, PLAY} state_t;

  typedef struct packed {
    logic [4:0] word;
    logic [7:0] dwell;
  } entry_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [4:0]             acc_q, acc_d;
  logic                   ce_q, ce_d;
  logic [8:0]             cnt_q, cnt_d;
  logic [DEPTH-1:0][12:0] mem_q;
  entry_t                 head;
  logic                   push, pop, empty;

  // Full blocks pushes outright, even when a pop frees a slot this cycle.
  assign in_if.in_ready = (level_q != LW'(DEPTH));
  assign push           = in_if.in_valid & in_if.in_ready;
  assign empty          = (level_q == '0);
  assign head           = entry_t'(mem_q[rd_ptr_q]);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ce_d     = ce_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        ce_d  = 1'b0;
        cnt_d = '0;
        if (run && !empty) pop = 1'b1;
      end
      PLAY: begin
        if (cnt_q == 9'd1) begin
          if (run && !empty) pop = 1'b1;
          else begin
            state_d = IDLE;
            acc_d   = '0;
            ce_d    = 1'b0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      state_d = PLAY;
      acc_d   = head.word;
      ce_d    = 1'b1;
      cnt_d   = (head.dwell == 8'd0) ? 9'd256 : {1'b0, head.dwell};
    end
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      acc_q    <= '0;
      ce_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      acc_q    <= acc_d;
      ce_q     <= ce_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is left unreset; level/pointers hide stale contents.
  always_ff @(posedge pclk) begin
    if (push) mem_q[wr_ptr_q] <= {in_if.in_word, in_if.in_dwell};
  end

  assign acc_in       = acc_q;
  assign clock_enable = ce_q;
  assign busy         = (state_q == PLAY);
  assign level        = level_q;
endmodule

// File: tb/tb_acc_word_sequencer.sv
// Directed bench for acc_word_sequencer: playout timing, FIFO order/full, dwell 0, run drop, reset.
module tb_acc_word_sequencer;
  logic       pclk;
  logic       reset;
  logic       run;
  logic [4:0] acc_in;
  logic       clock_enable;
  logic       busy;
  logic [2:0] level;
  int         n_chk;
  int         n_fail;

  acc_word_sequencer_if bus();

  acc_word_sequencer #(.DEPTH(4)) dut (
    .pclk         (pclk),
    .reset        (reset),
    .run          (run),
    .in_if        (bus),
    .acc_in       (acc_in),
    .clock_enable (clock_enable),
    .busy         (busy),
    .level        (level)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic push(input logic [4:0] w, input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    bus.in_dwell = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [4:0] exp_w [6];
    n_chk = 0;
    n_fail = 0;
    reset = 1'b0;
    run = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_word  = '0;
    bus.in_dwell = '0;
    step();
    step();
    check("rst_ce", clock_enable, 0);
    check("rst_acc", acc_in, 0);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_ready", bus.in_ready, 1);
    reset = 1'b1;
    step();

    // Single word {10,3} from IDLE with run high.
    run = 1'b1;
    push(5'd10, 8'd3);
    check("t1_after_push_ce", clock_enable, 0);
    check("t1_after_push_lvl", level, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      check("t1_ce", clock_enable, 1);
      check("t1_acc", acc_in, 10);
      step();
    end
    check("t1_end_ce", clock_enable, 0);
    check("t1_end_acc", acc_in, 0);
    check("t1_end_busy", busy, 0);

    // Two queued entries play back-to-back.
    run = 1'b0;
    push(5'd10, 8'd2);
    push(5'd5, 8'd4);
    check("t2_level", level, 2);
    check("t2_idle_ce", clock_enable, 0);
    run = 1'b1;
    step();
    exp_w = '{5'd10, 5'd10, 5'd5, 5'd5, 5'd5, 5'd5};
    for (int i = 0; i < 6; i++) begin
      check("t2_ce", clock_enable, 1);
      check("t2_busy", busy, 1);
      check("t2_acc", acc_in, exp_w[i]);
      step();
    end
    check("t2_end_ce", clock_enable, 0);
    check("t2_end_busy", busy, 0);

    // Fill to DEPTH; a push offered while full is dropped, even alongside a pop.
    run = 1'b0;
    for (int i = 1; i <= 4; i++) push(5'(i), 8'd1);
    check("t3_level_full", level, 4);
    check("t3_ready_full", bus.in_ready, 0);
    push(5'd31, 8'd1);
    check("t3_level_drop", level, 4);
    run = 1'b1;
    push(5'd31, 8'd1);
    check("t3_level_pop", level, 3);
    for (int i = 1; i <= 4; i++) begin
      check("t3_ce", clock_enable, 1);
      check("t3_acc", acc_in, i);
      step();
    end
    check("t3_end_ce", clock_enable, 0);
    check("t3_end_level", level, 0);

    // Dwell 0 means 256 cycles.
    push(5'd7, 8'd0);
    step();
    check("t4_acc", acc_in, 7);
    cnt = 0;
    while (clock_enable && cnt < 300) begin
      cnt++;
      step();
    end
    check("t4_dwell0_len", cnt, 256);
    check("t4_end_acc", acc_in, 0);

    // Dropping run mid-dwell finishes the current word, then idles.
    run = 1'b0;
    push(5'd3, 8'd5);
    push(5'd9, 8'd1);
    run = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      check("t5_ce", clock_enable, 1);
      check("t5_acc", acc_in, 3);
      if (i == 1) run = 1'b0;
      step();
    end
    check("t5_end_ce", clock_enable, 0);
    check("t5_end_busy", busy, 0);
    check("t5_end_level", level, 1);

    // Reset mid-PLAY with two entries still queued.
    push(5'd4, 8'd10);
    push(5'd6, 8'd2);
    push(5'd8, 8'd3);
    check("t6_level", level, 4);
    run = 1'b1;
    step();
    step();
    check("t6_acc_pre", acc_in, 4);
    check("t6_level_pre", level, 2);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_ce", clock_enable, 0);
    check("t6_async_acc", acc_in, 0);
    check("t6_async_level", level, 0);
    check("t6_async_busy", busy, 0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t6_no_play_ce", clock_enable, 0);
      check("t6_no_play_lvl", level, 0);
      step();
    end
    push(5'd12, 8'd2);
    check("t6_latency_ce0", clock_enable, 0);
    step();
    check("t6_new_ce", clock_enable, 1);
    check("t6_new_acc", acc_in, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
